phase_gen: RTL

PHASE_GEN -- requirements
Module: phase_gen

---
 rtl/phase_gen_pkg.sv | 13 +
 rtl/phase_cnt.sv | 36 +++
 rtl/phase_gen.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/phase_gen_pkg.sv
// phase_gen_pkg: shared definitions for the multi-phase clock generator.
//   - Sequencer state encoding (IDLE / HIGH / GAP).
//   - Default reset values for the active high-width and gap-width registers.
package phase_gen_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HIGH = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  localparam int DEF_RST_HIGH = 1;
  localparam int DEF_RST_GAP  = 1;

endpackage

// File: rtl/phase_cnt.sv
// phase_cnt: loadable down-counter used to time phase high and gap widths.
// Ports:
//   clk_i    - clock
//   clear_i  - asynchronous active-low reset
//   load     - load load_val (takes priority over en)
//   load_val - value to load
//   en       - decrement enable; the counter stops at zero
//   zero     - high while the count is zero
module phase_cnt
  import phase_gen_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic             clk_i,
  input  logic             clear_i,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk_i or negedge clear_i) begin
    if (!clear_i) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/phase_gen.sv
// phase_gen: non-overlapping multi-phase clock sequencer.
// Each phase is driven high for max(high,1) cycles followed by an all-low gap
// of 'gap' cycles; phases rotate 0..NUM_PHASES-1. New widths are staged in
// pending registers and take effect only when phase 0 next enters HIGH.
// Ports:
//   clk_i       - clock
//   clear_i     - asynchronous active-low reset
//   ssp_intr_i  - [1] freeze level, [0] single-step request (rising edge)
//   cfg_high_i  - requested high width (0 behaves as 1)
//   cfg_gap_i   - requested gap width (0 = phases abut)
//   cfg_load_i  - strobe capturing cfg_high_i/cfg_gap_i as pending config
//   phi_o       - one-hot-or-zero phase outputs
//   phase_idx_o - current / last driven phase index
//   round_o     - pulse when phase 0 restarts after a full round
//   frozen_o    - registered freeze indication
//   cfg_busy_o  - pending config waiting for the round boundary
//   clk_o       - pass-through of clk_i
//   clear_o     - pass-through of clear_i
module phase_gen
  import phase_gen_pkg::*;
#(
  parameter int NUM_PHASES = 2,
  parameter int CNT_W      = 4,
  parameter int RST_HIGH   = DEF_RST_HIGH,
  parameter int RST_GAP    = DEF_RST_GAP,
  localparam int IDX_W     = $clog2(NUM_PHASES)
) (
  input  logic                  clk_i,
  input  logic                  clear_i,
  input  logic [1:0]            ssp_intr_i,
  input  logic [CNT_W-1:0]      cfg_high_i,
  input  logic [CNT_W-1:0]      cfg_gap_i,
  input  logic                  cfg_load_i,
  output logic [NUM_PHASES-1:0] phi_o,
  output logic [IDX_W-1:0]      phase_idx_o,
  output logic                  round_o,
  output logic                  frozen_o,
  output logic                  cfg_busy_o,
  output logic                  clk_o,
  output logic                  clear_o
);

  // Counter load value for a high width: a width of 0 is timed as 1 cycle.
  function automatic logic [CNT_W-1:0] high_m1(input logic [CNT_W-1:0] h);
    return (h == '0) ? '0 : h - 1'b1;
  endfunction

  logic [1:0]       state;
  logic [CNT_W-1:0] act_high, act_gap, pend_high, pend_gap;
  logic             step_prev;

  logic             step_edge, adv, cnt_zero;
  logic             enter_high, enter_gap, apply_cfg;
  logic             cnt_load, cnt_en;
  logic [IDX_W-1:0] nidx, tgt_idx;
  logic [CNT_W-1:0] high_sel, cnt_val;

  assign clk_o   = clk_i;
  assign clear_o = clear_i;

  always_comb begin
    step_edge  = ssp_intr_i[0] & ~step_prev;
    // While frozen only a fresh step request lets one cycle through.
    adv        = ~ssp_intr_i[1] | step_edge;
    nidx       = (phase_idx_o == IDX_W'(NUM_PHASES - 1)) ? '0 : phase_idx_o + 1'b1;
    enter_high = 1'b0;
    enter_gap  = 1'b0;
    tgt_idx    = phase_idx_o;
    case (state)
      ST_IDLE: begin
        enter_high = 1'b1;
        tgt_idx    = '0;
      end
      ST_HIGH: begin
        if (cnt_zero) begin
          if (act_gap != '0) begin
            enter_gap = 1'b1;
          end else begin
            enter_high = 1'b1;
            tgt_idx    = nidx;
          end
        end
      end
      ST_GAP: begin
        if (cnt_zero) begin
          enter_high = 1'b1;
          tgt_idx    = nidx;
        end
      end
      default: ;
    endcase
    // Pending config is consumed exactly when phase 0 enters HIGH, so the
    // very first high period of the round already uses the new width.
    apply_cfg = enter_high && (tgt_idx == '0) && cfg_busy_o;
    high_sel  = apply_cfg ? pend_high : act_high;
    cnt_load  = adv && (enter_high || enter_gap);
    cnt_en    = adv && !(enter_high || enter_gap);
    cnt_val   = enter_gap ? (act_gap - 1'b1) : high_m1(high_sel);
  end

  phase_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk_i    (clk_i),
    .clear_i  (clear_i),
    .load     (cnt_load),
    .load_val (cnt_val),
    .en       (cnt_en),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk_i or negedge clear_i) begin
    if (!clear_i) begin
      state       <= ST_IDLE;
      phi_o       <= '0;
      phase_idx_o <= '0;
      round_o     <= 1'b0;
      frozen_o    <= 1'b0;
      step_prev   <= 1'b0;
    end else begin
      frozen_o  <= ssp_intr_i[1];
      step_prev <= ssp_intr_i[0];
      round_o   <= adv && enter_high && (tgt_idx == '0) && (state != ST_IDLE);
      if (adv && enter_high) begin
        state       <= ST_HIGH;
        phase_idx_o <= tgt_idx;
        phi_o       <= NUM_PHASES'(1) << tgt_idx;
      end else if (adv && enter_gap) begin
        state <= ST_GAP;
        phi_o <= '0;
      end
    end
  end

  // A load coinciding with the boundary stays pending for the next round.
  always_ff @(posedge clk_i or negedge clear_i) begin
    if (!clear_i) begin
      act_high   <= CNT_W'(RST_HIGH);
      act_gap    <= CNT_W'(RST_GAP);
      pend_high  <= CNT_W'(RST_HIGH);
      pend_gap   <= CNT_W'(RST_GAP);
      cfg_busy_o <= 1'b0;
    end else begin
      if (adv && apply_cfg) begin
        act_high <= pend_high;
        act_gap  <= pend_gap;
      end
      if (cfg_load_i) begin
        pend_high  <= cfg_high_i;
        pend_gap   <= cfg_gap_i;
        cfg_busy_o <= 1'b1;
      end else if (adv && apply_cfg) begin
        cfg_busy_o <= 1'b0;
      end
    end
  end

endmodule
